// File: rtl/maxpool2x2_stream_if.sv
// Stream bundle for maxpool2x2_stream: pixel input channel and pooled-result
// output channel, each with a valid/ready handshake.
interface maxpool2x2_stream_if #(
  parameter int DW = 18
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  // Pooling engine side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  // Producer/consumer side (upstream conv layer and downstream layer).
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pooling engine. Pixels arrive in raster order as
// sign-magnitude words. Even rows store per-column-pair maxima in a half-row
// line buffer; odd rows combine their own pair maximum with the stored one and
// emit one pooled value per window through a single output register.
module maxpool2x2_stream #(
  parameter int DW     = 18,
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28
) (
  input logic                 clk,
  input logic                 rst_n,
  maxpool2x2_stream_if.slave  s
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int NK = WIDTH / 2;
  localparam int KW = (NK > 1) ? $clog2(NK) : 1;

  // Odd or too-small map dimensions cannot be tiled by 2x2 windows.
  generate
    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
      $error("maxpool2x2_stream: WIDTH must be even and >= 2");
    end
    if ((HEIGHT % 2) != 0 || HEIGHT < 2) begin : g_bad_height
      $error("maxpool2x2_stream: HEIGHT must be even and >= 2");
    end
  endgenerate

  typedef enum logic {
    EVEN_ROW = 1'b0,
    ODD_ROW  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [DW-1:0] hreg_q;
  logic [DW-1:0] lbuf [NK];
  logic [KW-1:0] k;

  logic          in_ready;
  logic          in_fire;
  logic          col_last;
  logic          row_last;
  logic          buf_we;
  logic          out_load;
  logic [DW-1:0] pair_max;
  logic [DW-1:0] win_max;

  logic          out_valid_q;
  logic          out_last_q;
  logic [DW-1:0] out_data_q;

  // Sign-magnitude maximum. Differing signs pick the non-negative operand,
  // which also resolves +0 against -0 to +0. Equal operands return identical
  // bits, so no arithmetic ever alters the selected word.
  function automatic logic [DW-1:0] sm_max(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW-2:0] ma;
    logic [DW-2:0] mb;
    ma = a[DW-2:0];
    mb = b[DW-2:0];
    if (a[DW-1] != b[DW-1]) return a[DW-1] ? b : a;
    else if (!a[DW-1])      return (ma >= mb) ? a : b;
    else                    return (ma <= mb) ? a : b;
  endfunction

  // The block stalls only while a finished result waits for the consumer.
  assign in_ready    = !out_valid_q || s.out_ready;
  assign in_fire     = s.in_valid && in_ready;
  assign col_last    = (col_q == CW'(WIDTH - 1));
  assign row_last    = (row_q == RW'(HEIGHT - 1));
  assign k           = KW'(col_q >> 1);
  assign pair_max    = sm_max(hreg_q, s.in_data);
  assign win_max     = sm_max(lbuf[k], pair_max);

  assign s.in_ready  = in_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_last  = out_last_q;
  assign s.out_data  = out_data_q;

  // Row-parity state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EVEN_ROW;
    else        state_q <= state_d;
  end

  // Next row parity plus buffer-write / result-load strobes on odd columns.
  // NOTE: every signal gets its default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    buf_we   = 1'b0;
    out_load = 1'b0;
    if (in_fire) begin
      if (col_q[0]) begin
        if (state_q == EVEN_ROW) buf_we   = 1'b1;
        else                     out_load = 1'b1;
      end
      if (col_last) state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
    end
  end

  // Raster position: column wraps at the row end, row wraps at the frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (in_fire) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // Left pixel of the current column pair, held until its right partner arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  hreg_q <= '0;
    else if (in_fire && !col_q[0]) hreg_q <= s.in_data;
  end

  // Half-row buffer of even-row pair maxima.
  // NOTE: the line buffer carries no reset: each entry is written on the even
  // row before the odd row reads it, so it stays a plain RAM array.
  always_ff @(posedge clk) begin
    if (buf_we) lbuf[k] <= pair_max;
  end

  // Output register: a new result wins over clearing on a consumer handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (out_load) begin
      out_valid_q <= 1'b1;
      out_last_q  <= row_last && col_last;
      out_data_q  <= win_max;
    end else if (out_valid_q && s.out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream: a 4x4 instance for the directed
// cases and a 28x28 instance for back-to-back random frames. Expected results
// come from a value-level model of 2x2 max pooling over the whole frame.
module tb_maxpool2x2_stream;

  localparam int DW = 18;
  localparam int MW = DW - 1;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  maxpool2x2_stream_if #(.DW(DW)) s4  ();
  maxpool2x2_stream_if #(.DW(DW)) s28 ();

  maxpool2x2_stream #(.DW(DW), .WIDTH(4), .HEIGHT(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (s4.slave)
  );

  maxpool2x2_stream #(.DW(DW), .WIDTH(28), .HEIGHT(28)) dut28 (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (s28.slave)
  );

  int   tests = 0;
  int   fails = 0;
  res_t q4[$];
  res_t q28[$];
  res_t exp_q[$];
  bit   drv_done;

  // Record output handshakes; inputs only change just after the rising edge,
  // so a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && s4.out_valid && s4.out_ready)
      q4.push_back({s4.out_last, s4.out_data});
    if (rst_n === 1'b1 && s28.out_valid && s28.out_ready)
      q28.push_back({s28.out_last, s28.out_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Signed value comparison; equal values with different bits can only be
  // +0 and -0, and then +0 is the answer.
  function automatic logic [DW-1:0] ref_max(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int va;
    int vb;
    va = int'(a[DW-2:0]);
    vb = int'(b[DW-2:0]);
    if (a[DW-1]) va = -va;
    if (b[DW-1]) vb = -vb;
    if (va > vb) return a;
    if (vb > va) return b;
    return (a == b) ? a : '0;
  endfunction

  // Append the pooled results of one w x h raster frame to exp_q.
  function automatic void model(input logic [DW-1:0] px[$], input int w, input int h);
    logic [DW-1:0] m;
    for (int wr = 0; wr < h / 2; wr++) begin
      for (int wc = 0; wc < w / 2; wc++) begin
        m = px[(2 * wr) * w + 2 * wc];
        m = ref_max(m, px[(2 * wr) * w + 2 * wc + 1]);
        m = ref_max(m, px[(2 * wr + 1) * w + 2 * wc]);
        m = ref_max(m, px[(2 * wr + 1) * w + 2 * wc + 1]);
        exp_q.push_back({(wr == h / 2 - 1) && (wc == w / 2 - 1), m});
      end
    end
  endfunction

  function automatic logic [DW-1:0] rnd_px();
    logic          sgn;
    logic [MW-1:0] mag;
    sgn = 1'($urandom_range(0, 1));
    // Small magnitudes half the time so ties and +/-0 clashes occur often.
    mag = ($urandom_range(0, 1) == 0) ? MW'($urandom_range(0, 3)) : MW'($urandom);
    return {sgn, mag};
  endfunction

  task automatic send4(input logic [DW-1:0] px);
    bit acc = 1'b0;
    s4.in_valid = 1'b1;
    s4.in_data  = px;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = s4.in_ready;
      tick();
    end
    s4.in_valid = 1'b0;
    check("send4_accept", 32'(acc), 32'd1);
  endtask

  task automatic send28(input logic [DW-1:0] px);
    bit acc = 1'b0;
    s28.in_valid = 1'b1;
    s28.in_data  = px;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = s28.in_ready;
      tick();
    end
    s28.in_valid = 1'b0;
    check("send28_accept", 32'(acc), 32'd1);
  endtask

  // Stream one 4x4 frame; with lat set (and out_ready held high) out_valid must
  // be up exactly one cycle after each window's bottom-right pixel.
  task automatic frame4(input logic [DW-1:0] px[$], input bit lat);
    for (int i = 0; i < 16; i++) begin
      send4(px[i]);
      if (lat)
        check($sformatf("latency_valid_px%0d", i + 1), 32'(s4.out_valid),
              32'(((i / 4) % 2 == 1) && (i % 2 == 1)));
    end
  endtask

  task automatic compare(input string tag, input res_t got[$]);
    check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), 32'(got[i].data), 32'(exp_q[i].data));
      check($sformatf("%s_last%0d", tag, i), 32'(got[i].last), 32'(exp_q[i].last));
    end
  endtask

  initial begin
    logic [DW-1:0] px[$];
    logic [DW-1:0] px28[$];
    logic [DW-1:0] spec_basic[4];
    logic [DW-1:0] spec_sign[4];

    spec_basic = '{18'd6, 18'd8, 18'd14, 18'd16};
    spec_sign  = '{18'h20002, 18'h00000, 18'h00000, 18'h20000};

    s4.in_valid   = 1'b0;
    s4.in_data    = '0;
    s4.out_ready  = 1'b1;
    s28.in_valid  = 1'b0;
    s28.in_data   = '0;
    s28.out_ready = 1'b1;
    rst_n         = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) tick();

    // Reset values.
    check("rst_out_valid", 32'(s4.out_valid), 32'd0);
    check("rst_out_last",  32'(s4.out_last),  32'd0);
    check("rst_out_data",  32'(s4.out_data),  32'd0);
    check("rst_in_ready",  32'(s4.in_ready),  32'd1);
    check("rst28_in_ready", 32'(s28.in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // 4x4 basic ramp with per-pixel latency checks.
    q4.delete();
    px.delete();
    for (int i = 1; i <= 16; i++) px.push_back(DW'(i));
    frame4(px, 1'b1);
    repeat (4) tick();
    exp_q.delete();
    model(px, 4, 4);
    compare("basic", q4);
    for (int i = 0; i < 4 && i < q4.size(); i++)
      check($sformatf("basic_spec%0d", i), 32'(q4[i].data), 32'(spec_basic[i]));

    // Signed windows and +/-0 resolution.
    q4.delete();
    px = '{18'h20005, 18'h20002, 18'h20001, 18'h00000,
           18'h20009, 18'h20003, 18'h20007, 18'h20002,
           18'h20000, 18'h20000, 18'h20000, 18'h20000,
           18'h20000, 18'h00000, 18'h20000, 18'h20000};
    frame4(px, 1'b0);
    repeat (4) tick();
    exp_q.delete();
    model(px, 4, 4);
    compare("signed", q4);
    for (int i = 0; i < 4 && i < q4.size(); i++)
      check($sformatf("signed_spec%0d", i), 32'(q4[i].data), 32'(spec_sign[i]));

    // Backpressure: stall the first result for five cycles.
    q4.delete();
    px.delete();
    for (int i = 1; i <= 16; i++) px.push_back(DW'(i));
    fork
      frame4(px, 1'b0);
      begin
        for (int n = 0; n < 100 && s4.out_valid !== 1'b1; n++) tick();
        check("bp_first_valid", 32'(s4.out_valid), 32'd1);
        s4.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("bp_hold_data",  32'(s4.out_data),  32'd6);
          check("bp_hold_valid", 32'(s4.out_valid), 32'd1);
          check("bp_in_ready",   32'(s4.in_ready),  32'd0);
        end
        tick();
        s4.out_ready = 1'b1;
      end
    join
    repeat (4) tick();
    exp_q.delete();
    model(px, 4, 4);
    compare("backpressure", q4);

    // Reset mid-frame while a result is stalled in the output register.
    for (int i = 1; i <= 7; i++) send4(DW'(i));
    s4.out_ready = 1'b0;
    send4(DW'(8));
    check("mid_pre_valid", 32'(s4.out_valid), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(s4.out_valid), 32'd0);
    check("mid_rst_last",  32'(s4.out_last),  32'd0);
    check("mid_rst_data",  32'(s4.out_data),  32'd0);
    check("mid_rst_ready", 32'(s4.in_ready),  32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    s4.out_ready = 1'b1;
    tick();
    q4.delete();
    px.delete();
    for (int i = 0; i < 16; i++) px.push_back(rnd_px());
    frame4(px, 1'b0);
    repeat (4) tick();
    exp_q.delete();
    model(px, 4, 4);
    compare("after_reset", q4);

    // Two back-to-back 28x28 random frames with random consumer stalls.
    q28.delete();
    px28.delete();
    for (int i = 0; i < 2 * 28 * 28; i++) px28.push_back(rnd_px());
    drv_done = 1'b0;
    fork
      begin
        foreach (px28[i]) send28(px28[i]);
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          s28.out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    s28.out_ready = 1'b1;
    repeat (6) tick();
    exp_q.delete();
    px.delete();
    for (int i = 0; i < 784; i++) px.push_back(px28[i]);
    model(px, 28, 28);
    px.delete();
    for (int i = 784; i < 1568; i++) px.push_back(px28[i]);
    model(px, 28, 28);
    compare("b2b", q28);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
